// File: rtl/ddr3_core_sched.sv
// DDR3 command scheduler: open-page bank tracking, PRE/ACT/RD/WR ordering and periodic PREALL+REF.
// Optional macro DDR3_SCHED_CLOSE_PAGE_EN: every RD/WR auto-precharges and open-row tracking is removed.
module ddr3_core_sched #(
    parameter int DDR_MHZ    = 50,
    parameter int DDR_COL_W  = 10,
    parameter int DDR_BANK_W = 3,
    parameter int DDR_ROW_W  = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  init_done_i,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [31:0]           req_addr_i,
    input  logic [127:0]          req_wrdata_i,
    input  logic [15:0]           req_wrmask_i,
    output logic                  req_accept_o,
    output logic                  resp_valid_o,
    output logic [127:0]          resp_rddata_o,
    output logic [3:0]            seq_command_o,
    output logic [DDR_ROW_W-1:0]  seq_address_o,
    output logic [DDR_BANK_W-1:0] seq_bank_o,
    output logic [127:0]          seq_wrdata_o,
    output logic [15:0]           seq_wrmask_o,
    input  logic                  seq_accept_i,
    input  logic [127:0]          seq_rddata_i,
    input  logic                  seq_rddata_valid_i
);
    localparam int REFI_CYCLES = (DDR_MHZ * 7800) / 1000;
    localparam int TMR_W       = $clog2(REFI_CYCLES);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFI_CYCLES - 1);
    localparam int NUM_BANKS   = 2 ** DDR_BANK_W;
    localparam int ROW_LSB     = DDR_COL_W + DDR_BANK_W + 1;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    localparam logic [2:0] ST_INIT_WAIT = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_PRE       = 3'd2;
    localparam logic [2:0] ST_ACT       = 3'd3;
    localparam logic [2:0] ST_RW        = 3'd4;
    localparam logic [2:0] ST_PREALL    = 3'd5;
    localparam logic [2:0] ST_REF       = 3'd6;

    logic [2:0]            state_q, state_d;
    logic                  refresh_pending_q, refresh_pending_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [127:0]          resp_rddata_q, resp_rddata_d;
`ifndef DDR3_SCHED_CLOSE_PAGE_EN
    logic [NUM_BANKS-1:0]                open_q, open_d;
    logic [NUM_BANKS-1:0][DDR_ROW_W-1:0] row_q, row_d;
`endif

    logic [DDR_COL_W-1:0]  req_col;
    logic [DDR_BANK_W-1:0] req_bank;
    logic [DDR_ROW_W-1:0]  req_row;
    logic [DDR_ROW_W-1:0]  rw_addr;
    logic [3:0]            cmd;
    logic [DDR_ROW_W-1:0]  addr;
    logic [DDR_BANK_W-1:0] bank;
    logic                  unused_addr_bits;

    assign req_col  = {req_addr_i[DDR_COL_W:4], 3'b000};
    assign req_bank = req_addr_i[DDR_COL_W+1 +: DDR_BANK_W];
    assign req_row  = req_addr_i[ROW_LSB +: DDR_ROW_W];
    assign unused_addr_bits = ^{req_addr_i[3:0], req_addr_i[31:ROW_LSB+DDR_ROW_W]};

    // A10 on a column command selects auto-precharge.
    always_comb begin
        rw_addr     = DDR_ROW_W'(req_col);
`ifdef DDR3_SCHED_CLOSE_PAGE_EN
        rw_addr[10] = 1'b1;
`else
        rw_addr[10] = 1'b0;
`endif
    end

    always_comb begin
        state_d           = state_q;
        refresh_pending_d = refresh_pending_q;
        cmd               = CMD_NOP;
        addr              = '0;
        bank              = '0;
`ifndef DDR3_SCHED_CLOSE_PAGE_EN
        open_d            = open_q;
        row_d             = row_q;
`endif
        case (state_q)
            ST_INIT_WAIT: if (init_done_i) state_d = ST_IDLE;
            ST_IDLE: begin
                if (refresh_pending_q) begin
                    state_d = ST_PREALL;
                end else if (req_valid_i) begin
`ifdef DDR3_SCHED_CLOSE_PAGE_EN
                    state_d = ST_ACT;
`else
                    if (!open_q[req_bank])               state_d = ST_ACT;
                    else if (row_q[req_bank] == req_row) state_d = ST_RW;
                    else                                 state_d = ST_PRE;
`endif
                end
            end
            ST_PRE: begin
                cmd  = CMD_PRE;
                bank = req_bank;
                if (seq_accept_i) begin
`ifndef DDR3_SCHED_CLOSE_PAGE_EN
                    open_d[req_bank] = 1'b0;
`endif
                    state_d = ST_ACT;
                end
            end
            ST_ACT: begin
                cmd  = CMD_ACT;
                addr = req_row;
                bank = req_bank;
                if (seq_accept_i) begin
`ifndef DDR3_SCHED_CLOSE_PAGE_EN
                    open_d[req_bank] = 1'b1;
                    row_d[req_bank]  = req_row;
`endif
                    state_d = ST_RW;
                end
            end
            ST_RW: begin
                cmd  = req_write_i ? CMD_WR : CMD_RD;
                addr = rw_addr;
                bank = req_bank;
                if (seq_accept_i) state_d = ST_IDLE;
            end
            ST_PREALL: begin
                cmd      = CMD_PRE;
                addr[10] = 1'b1;
                if (seq_accept_i) begin
`ifndef DDR3_SCHED_CLOSE_PAGE_EN
                    open_d = '0;
`endif
                    state_d = ST_REF;
                end
            end
            ST_REF: begin
                cmd = CMD_REF;
                if (seq_accept_i) begin
                    refresh_pending_d = 1'b0;
                    state_d           = ST_IDLE;
                end
            end
            default: state_d = ST_INIT_WAIT;
        endcase

        // A fresh expiry wins over a same-cycle REF accept; an expiry while pending merges.
        if (timer_q == '0) begin
            timer_d           = TMR_RELOAD;
            refresh_pending_d = 1'b1;
        end else begin
            timer_d = timer_q - 1'b1;
        end

        resp_valid_d  = seq_rddata_valid_i;
        resp_rddata_d = seq_rddata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= ST_INIT_WAIT;
            refresh_pending_q <= 1'b0;
            timer_q           <= TMR_RELOAD;
            resp_valid_q      <= 1'b0;
            resp_rddata_q     <= '0;
`ifndef DDR3_SCHED_CLOSE_PAGE_EN
            open_q            <= '0;
            row_q             <= '0;
`endif
        end else begin
            state_q           <= state_d;
            refresh_pending_q <= refresh_pending_d;
            timer_q           <= timer_d;
            resp_valid_q      <= resp_valid_d;
            resp_rddata_q     <= resp_rddata_d;
`ifndef DDR3_SCHED_CLOSE_PAGE_EN
            open_q            <= open_d;
            row_q             <= row_d;
`endif
        end
    end

    assign req_accept_o  = (state_q == ST_RW) && seq_accept_i && !rst_i;
    assign resp_valid_o  = resp_valid_q;
    assign resp_rddata_o = resp_rddata_q;
    assign seq_command_o = cmd;
    assign seq_address_o = addr;
    assign seq_bank_o    = bank;
    assign seq_wrdata_o  = req_wrdata_i;
    assign seq_wrmask_o  = req_wrmask_i;

endmodule

// File: tb/tb_ddr3_core_sched.sv
// Directed bench for ddr3_core_sched: table of requests with expected command streams plus
// hand-written refresh, stall/reset and refresh-vs-request sequences.
module tb_ddr3_core_sched;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101,
                           WR = 4'b0100, PRE = 4'b0010, REF = 4'b0001;
`ifdef DDR3_SCHED_CLOSE_PAGE_EN
    localparam logic [14:0] A10 = 15'h400;
`else
    localparam logic [14:0] A10 = 15'h000;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1, init_done_i = 1'b0;
    logic         req_valid_i = 1'b0, req_write_i = 1'b0;
    logic [31:0]  req_addr_i = '0;
    logic [127:0] req_wrdata_i = '0;
    logic [15:0]  req_wrmask_i = '0;
    logic         req_accept_o, resp_valid_o;
    logic [127:0] resp_rddata_o, seq_wrdata_o;
    logic [3:0]   seq_command_o;
    logic [14:0]  seq_address_o;
    logic [2:0]   seq_bank_o;
    logic [15:0]  seq_wrmask_o;
    logic         seq_accept_i = 1'b0;
    logic [127:0] seq_rddata_i = '0;
    logic         seq_rddata_valid_i = 1'b0;

    always #5 clk_i = ~clk_i;

    ddr3_core_sched dut (
        .clk_i(clk_i), .rst_i(rst_i), .init_done_i(init_done_i),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_wrdata_i(req_wrdata_i), .req_wrmask_i(req_wrmask_i), .req_accept_o(req_accept_o),
        .resp_valid_o(resp_valid_o), .resp_rddata_o(resp_rddata_o),
        .seq_command_o(seq_command_o), .seq_address_o(seq_address_o), .seq_bank_o(seq_bank_o),
        .seq_wrdata_o(seq_wrdata_o), .seq_wrmask_o(seq_wrmask_o), .seq_accept_i(seq_accept_i),
        .seq_rddata_i(seq_rddata_i), .seq_rddata_valid_i(seq_rddata_valid_i)
    );

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Sequencer model: accepts a pending command every other cycle so commands are held a while.
    int          cyc = 0;
    logic        acc_en = 1'b1;
    logic        stall_tog = 1'b0;
    int          acc_total = 0;
    logic [3:0]  lg_cmd[$];
    logic [14:0] lg_adr[$];
    logic [2:0]  lg_bank[$];

    always @(posedge clk_i) if (rst_i) cyc = 0; else cyc++;

    always @(negedge clk_i) begin
        stall_tog    = ~stall_tog;
        seq_accept_i = acc_en && stall_tog && !rst_i && (seq_command_o != NOP);
        #1;
        if (seq_accept_i) begin
            lg_cmd.push_back(seq_command_o);
            lg_adr.push_back(seq_address_o);
            lg_bank.push_back(seq_bank_o);
        end
        if (req_accept_o) acc_total++;
    end

    typedef struct {
        logic             rst;
        logic             wr;
        logic [31:0]      addr;
        int               n;
        logic [3:0][3:0]  cmd;
        logic [3:0][14:0] adr;
        logic [3:0][2:0]  bank;
    } vec_t;
    vec_t vecs[8];

    task automatic set_req(input int i, input logic r, input logic w, input logic [31:0] a);
        vecs[i].rst = r; vecs[i].wr = w; vecs[i].addr = a; vecs[i].n = 0;
        vecs[i].cmd = '0; vecs[i].adr = '0; vecs[i].bank = '0;
    endtask

    task automatic add(input int i, input logic [3:0] c, input logic [14:0] a, input logic [2:0] b);
        vecs[i].cmd[vecs[i].n] = c; vecs[i].adr[vecs[i].n] = a; vecs[i].bank[vecs[i].n] = b;
        vecs[i].n++;
    endtask

    task automatic do_reset(input logic init);
        @(negedge clk_i);
        rst_i = 1'b1; init_done_i = init; req_valid_i = 1'b0; seq_rddata_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic wait_accept(input int base, output logic seen);
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk_i); #2;
            if (acc_total > base) begin seen = 1'b1; break; end
        end
    endtask

    task automatic run_req(input int i);
        int   lb, ab;
        logic seen;
        logic [127:0] d;
        if (vecs[i].rst) do_reset(1'b1);
`ifdef DDR3_SCHED_CLOSE_PAGE_EN
        begin
            logic [31:0] a;
            logic w;
            a = vecs[i].addr; w = vecs[i].wr;
            set_req(i, vecs[i].rst, w, a);
            add(i, ACT, a[28:14], a[13:11]);
            add(i, w ? WR : RD, {5'b0, a[10:4], 3'b000} | A10, a[13:11]);
        end
`endif
        lb = lg_cmd.size(); ab = acc_total;
        d  = {4{32'h5A00_0000 + 32'(i)}};
        @(negedge clk_i); #2;
        req_valid_i = 1'b1; req_write_i = vecs[i].wr; req_addr_i = vecs[i].addr;
        req_wrdata_i = d; req_wrmask_i = 16'h00FF ^ 16'(i);
        wait_accept(ab, seen);
        chk($sformatf("v%0d_accept_seen", i), seen, 1'b1);
        if (vecs[i].wr) chk($sformatf("v%0d_wrdata", i), seq_wrdata_o, d);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk($sformatf("v%0d_ncmd", i), lg_cmd.size() - lb, vecs[i].n);
        for (int k = 0; k < vecs[i].n && lb + k < lg_cmd.size(); k++) begin
            chk($sformatf("v%0d_cmd%0d", i, k), lg_cmd[lb+k], vecs[i].cmd[k]);
            chk($sformatf("v%0d_adr%0d", i, k), lg_adr[lb+k], vecs[i].adr[k]);
            chk($sformatf("v%0d_bank%0d", i, k), lg_bank[lb+k], vecs[i].bank[k]);
        end
        if (!vecs[i].wr) begin
            @(negedge clk_i); #2;
            seq_rddata_i = ~d; seq_rddata_valid_i = 1'b1;
            @(negedge clk_i); #2;
            chk($sformatf("v%0d_resp_valid", i), resp_valid_o, 1'b1);
            chk($sformatf("v%0d_resp_data", i), resp_rddata_o, ~d);
            seq_rddata_valid_i = 1'b0;
            @(negedge clk_i); #2;
            chk($sformatf("v%0d_resp_drop", i), resp_valid_o, 1'b0);
        end
        chk($sformatf("v%0d_one_accept", i), acc_total - ab, 1);
    endtask

    initial begin
        int   lb, ab, first;
        logic seen;

        set_req(0, 1, 0, 32'h0000_0040); add(0, ACT, 15'h000, 3'd0); add(0, RD, 15'h020 | A10, 3'd0);
        set_req(1, 1, 1, 32'h0000_0800); add(1, ACT, 15'h000, 3'd1); add(1, WR, 15'h000 | A10, 3'd1);
        set_req(2, 0, 0, 32'h0000_0810); add(2, RD, 15'h008, 3'd1);
        set_req(3, 1, 0, 32'h0000_0800); add(3, ACT, 15'h000, 3'd1); add(3, RD, 15'h000, 3'd1);
        set_req(4, 0, 0, 32'h0010_0800); add(4, PRE, 15'h000, 3'd1); add(4, ACT, 15'h040, 3'd1);
                                         add(4, RD, 15'h000, 3'd1);
        set_req(5, 0, 1, 32'h0000_1000); add(5, ACT, 15'h000, 3'd2); add(5, WR, 15'h000, 3'd2);
        set_req(6, 0, 0, 32'h0010_0830); add(6, RD, 15'h018, 3'd1);
        set_req(7, 0, 1, 32'h0000_0800); add(7, PRE, 15'h000, 3'd1); add(7, ACT, 15'h000, 3'd1);
                                         add(7, WR, 15'h000, 3'd1);

        // Reset values.
        do_reset(1'b0);
        #2;
        chk("rst_cmd", seq_command_o, NOP);
        chk("rst_addr", seq_address_o, 15'h0);
        chk("rst_bank", seq_bank_o, 3'h0);
        chk("rst_req_accept", req_accept_o, 1'b0);
        chk("rst_resp_valid", resp_valid_o, 1'b0);
        chk("rst_resp_data", resp_rddata_o, 128'h0);

        // Idle refresh: nothing until the first PREALL, which appears at cycle 391.
        lb = lg_cmd.size();
        while (cyc < 10) @(negedge clk_i);
        init_done_i = 1'b1;
        first = -1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk_i); #2;
            if (seq_command_o != NOP) begin first = cyc; break; end
        end
        chk("ref_first_cycle", first, 391);
        chk("ref_preall_cmd", seq_command_o, PRE);
        chk("ref_preall_addr", seq_address_o, 15'h400);
        chk("ref_preall_bank", seq_bank_o, 3'd0);
        for (int t = 0; t < 20 && lg_cmd.size() < lb + 2; t++) @(negedge clk_i);
        chk("ref_log_n", lg_cmd.size() - lb, 2);
        if (lg_cmd.size() >= lb + 2) begin
            chk("ref_log0", lg_cmd[lb], PRE);
            chk("ref_log1", lg_cmd[lb+1], REF);
        end

        for (int i = 0; i < 8; i++) run_req(i);

        // ACT held while the sequencer stalls, then reset drops the request.
        do_reset(1'b1);
        acc_en = 1'b0; ab = acc_total;
        @(negedge clk_i); #2;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_0040;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk_i); #2;
            if (seq_command_o == ACT) begin seen = 1'b1; break; end
        end
        chk("hold_act_seen", seen, 1'b1);
        for (int t = 0; t < 20; t++) begin
            chk($sformatf("hold%0d_cmd", t), {seq_command_o, seq_address_o, seq_bank_o},
                {ACT, 15'h000, 3'd0});
            chk($sformatf("hold%0d_acc", t), req_accept_o, 1'b0);
            @(negedge clk_i); #2;
        end
        init_done_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i); #2;
        chk("hold_rst_cmd", seq_command_o, NOP);
        chk("hold_rst_acc", req_accept_o, 1'b0);
        rst_i = 1'b0; acc_en = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk_i); #2;
            chk($sformatf("init_wait%0d_cmd", t), seq_command_o, NOP);
        end
        chk("hold_no_accept", acc_total - ab, 0);
        req_valid_i = 1'b0;

        // Refresh and request both waiting when IDLE is first reached: refresh wins.
        do_reset(1'b0);
        lb = lg_cmd.size(); ab = acc_total;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_0040;
        repeat (400) @(negedge clk_i);
        init_done_i = 1'b1;
        wait_accept(ab, seen);
        chk("race_accept_seen", seen, 1'b1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("race_ncmd", lg_cmd.size() - lb, 4);
        if (lg_cmd.size() >= lb + 4) begin
            chk("race_c0", {lg_cmd[lb],   lg_adr[lb],   lg_bank[lb]},   {PRE, 15'h400, 3'd0});
            chk("race_c1", lg_cmd[lb+1], REF);
            chk("race_c2", {lg_cmd[lb+2], lg_adr[lb+2], lg_bank[lb+2]}, {ACT, 15'h000, 3'd0});
            chk("race_c3", {lg_cmd[lb+3], lg_adr[lb+3], lg_bank[lb+3]}, {RD, 15'h020 | A10, 3'd0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
